data_sram_resp: RTL and testbench
=================================

DATA_SRAM_RESP -- requirements
Module: data_sram_resp

Interface
REQ-001 Parameter ADDR_W, default 10, meaning word-address width; the array holds 2^ADDR_W 32-bit words.
REQ-002 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 resetn  input  1  reset, asynchronous and active-low.
REQ-004 data_sram_en  input  1  CPU access enable for the current cycle.
REQ-005 data_sram_we  input  1  CPU write when 1, read when 0; qualified by data_sram_en.
REQ-006 data_sram_addr  input  32  CPU byte address; word index is addr[ADDR_W+1:2].
REQ-007 data_sram_wdata  input  32  CPU write data.
REQ-008 data_sram_rdata  output  32  CPU read data, registered.
REQ-009 host_req_valid  input  1  host loader/debug request valid.
REQ-010 host_req_ready  output  1  host request accepted this cycle when it is high together with valid.
REQ-011 host_we  input  1  host write when 1, read when 0.
REQ-012 host_addr  input  ADDR_W  host word index.
REQ-013 host_wdata  input  32  host write data.
REQ-014 host_rsp_valid  output  1  host response pending.
REQ-015 host_rsp_ready  input  1  host consumes the response.
REQ-016 host_rdata  output  32  host read data; 0 for write responses.
REQ-017 err_cnt  output  16  count of out-of-range CPU accesses.

Function
REQ-018 The block SHALL contain a single-port 32-bit array of 2^ADDR_W words, with one access per cycle.
REQ-019 CPU priority: when data_sram_en=1, the CPU SHALL own the array port that cycle.
REQ-020 CPU write: en=1 and we=1 SHALL write wdata to the indexed word at the clock edge; data_sram_rdata is unchanged.
REQ-021 CPU read: en=1 and we=0 SHALL load data_sram_rdata with the indexed word at the edge, giving 1-cycle latency.
REQ-022 data_sram_rdata SHALL hold its last value in every cycle without a CPU read.
REQ-023 A read in the cycle after a write to the same word SHALL return the new data.
REQ-024 Out-of-range: if data_sram_addr[31:ADDR_W+2] is nonzero, a write SHALL be dropped and a read SHALL return 0.
REQ-025 Each out-of-range access SHALL increment err_cnt by 1, saturating at 16'hFFFF.
REQ-026 The host FSM SHALL have two states, IDLE and RSP.
REQ-027 host_req_ready SHALL equal (state==IDLE) and not data_sram_en, combinationally.
REQ-028 Accept means valid and ready in IDLE: the array access SHALL be performed that cycle and the FSM SHALL go to RSP.
REQ-029 On entry to RSP, host_rsp_valid SHALL be 1 and host_rdata SHALL hold the read word, or 0 for a write.
REQ-030 RSP SHALL hold host_rsp_valid and host_rdata stable until host_rsp_ready=1, then return to IDLE the next cycle.
REQ-031 No new host request SHALL be accepted while in RSP; back-to-back host accesses therefore take at least 2 cycles each.
REQ-032 If host_req_valid is high while data_sram_en=1, the host SHALL stall with no array access; the request stays pending without loss.
REQ-033 CPU and host addressing the same word in consecutive cycles SHALL observe program order at the clock edges.

Reset
REQ-034 On resetn=0: data_sram_rdata=0, host_rsp_valid=0, host_rdata=0, err_cnt=0, and FSM=IDLE, all immediately and without waiting for clk.
REQ-035 A host response pending at reset SHALL be discarded.
REQ-036 Array contents SHALL NOT be reset.
REQ-037 No array write SHALL occur while resetn=0.

Verification
REQ-038 CPU write 0xDEADBEEF to addr 0x10, then read 0x10 the next cycle -> rdata=0xDEADBEEF one cycle after the read; rdata holds through idle cycles.
REQ-039 Host write 0x12345678 at word 5 while the CPU is idle -> ready=1, rsp_valid=1 the next cycle with host_rdata=0; CPU read of addr 0x14 -> 0x12345678.
REQ-040 Host read requested while the CPU has en=1 for 3 cycles -> ready=0 for those 3 cycles, accepted in the 4th; rsp_valid is held while rsp_ready=0 for 2 cycles, then drops 1 cycle after rsp_ready=1.
REQ-041 CPU read and write with addr 0x0001_0000 (ADDR_W=10) -> read returns 0, write leaves the array unchanged, err_cnt=2; 70000 such accesses -> err_cnt=0xFFFF.
REQ-042 Assert resetn low mid-RSP, asynchronously between edges -> rsp_valid=0, rdata=0, err_cnt=0 immediately; after release, word 5 still reads 0x12345678.

Source files
------------

// File: rtl/data_sram_resp_if.sv
// Bus bundle for data_sram_resp: CPU SRAM port, host request/response channel
// and the out-of-range error counter.
interface data_sram_resp_if #(
  parameter int ADDR_W = 10
);
  logic              data_sram_en;
  logic              data_sram_we;
  logic [31:0]       data_sram_addr;
  logic [31:0]       data_sram_wdata;
  logic [31:0]       data_sram_rdata;

  logic              host_req_valid;
  logic              host_req_ready;
  logic              host_we;
  logic [ADDR_W-1:0] host_addr;
  logic [31:0]       host_wdata;
  logic              host_rsp_valid;
  logic              host_rsp_ready;
  logic [31:0]       host_rdata;

  logic [15:0]       err_cnt;

  // Driver side: the CPU core and the host loader/debugger.
  modport master (
    output data_sram_en, data_sram_we, data_sram_addr, data_sram_wdata,
    input  data_sram_rdata,
    output host_req_valid, host_we, host_addr, host_wdata, host_rsp_ready,
    input  host_req_ready, host_rsp_valid, host_rdata,
    input  err_cnt
  );

  // Memory side.
  modport slave (
    input  data_sram_en, data_sram_we, data_sram_addr, data_sram_wdata,
    output data_sram_rdata,
    input  host_req_valid, host_we, host_addr, host_wdata, host_rsp_ready,
    output host_req_ready, host_rsp_valid, host_rdata,
    output err_cnt
  );
endinterface

// File: rtl/data_sram_resp.sv
// Single-port 32-bit data SRAM shared by a CPU port (always wins) and a host
// request/response port that is served only in cycles the CPU leaves idle.
module data_sram_resp #(
  parameter int ADDR_W = 10
) (
  input logic              clk,
  input logic              resetn,
  data_sram_resp_if.slave  bus
);
  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic {IDLE, RSP} state_t;

  logic [31:0] mem [DEPTH];

  state_t      state_q;
  logic [31:0] cpu_rdata_q;
  logic        rsp_valid_q;
  logic [31:0] host_rdata_q;
  logic [15:0] err_cnt_q;
  logic [15:0] err_cnt_d;

  logic [ADDR_W-1:0] cpu_idx;
  logic              cpu_oor;
  logic              cpu_rd;
  logic              host_accept;
  logic [ADDR_W-1:0] port_addr;
  logic              port_we;
  logic [31:0]       port_wdata;
  logic              unused_addr_lsb;

  assign cpu_idx         = bus.data_sram_addr[ADDR_W+1:2];
  assign cpu_oor         = |bus.data_sram_addr[31:ADDR_W+2];
  assign cpu_rd          = bus.data_sram_en && !bus.data_sram_we;
  assign unused_addr_lsb = &{1'b0, bus.data_sram_addr[1:0]};

  assign bus.host_req_ready = (state_q == IDLE) && !bus.data_sram_en;
  assign host_accept        = bus.host_req_valid && bus.host_req_ready;

  // One shared array port: the CPU owns it whenever enabled, else an accepted host request.
  always_comb begin
    port_addr  = bus.host_addr;
    port_we    = host_accept && bus.host_we;
    port_wdata = bus.host_wdata;
    if (bus.data_sram_en) begin
      port_addr  = cpu_idx;
      port_we    = bus.data_sram_we && !cpu_oor;
      port_wdata = bus.data_sram_wdata;
    end
  end

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (bus.data_sram_en && cpu_oor && (err_cnt_q != 16'hFFFF)) begin
      err_cnt_d = err_cnt_q + 16'd1;
    end
  end

  // Array contents are never reset, but writes are blocked while reset is held.
  always_ff @(posedge clk) begin
    if (resetn && port_we) begin
      mem[port_addr] <= port_wdata;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= IDLE;
      cpu_rdata_q  <= 32'd0;
      rsp_valid_q  <= 1'b0;
      host_rdata_q <= 32'd0;
      err_cnt_q    <= 16'd0;
    end else begin
      err_cnt_q <= err_cnt_d;
      if (cpu_rd) begin
        cpu_rdata_q <= cpu_oor ? 32'd0 : mem[port_addr];
      end
      case (state_q)
        IDLE: begin
          if (host_accept) begin
            state_q      <= RSP;
            rsp_valid_q  <= 1'b1;
            host_rdata_q <= bus.host_we ? 32'd0 : mem[port_addr];
          end
        end
        RSP: begin
          if (bus.host_rsp_ready) begin
            state_q     <= IDLE;
            rsp_valid_q <= 1'b0;
          end
        end
        default: begin
          state_q     <= IDLE;
          rsp_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.data_sram_rdata = cpu_rdata_q;
  assign bus.host_rsp_valid  = rsp_valid_q;
  assign bus.host_rdata      = host_rdata_q;
  assign bus.err_cnt         = err_cnt_q;
endmodule

// File: tb/tb_data_sram_resp.sv
// Directed and randomized checks of data_sram_resp against a transaction-level
// model of the memory, the host handshake and the error counter.
module tb_data_sram_resp;
  localparam int ADDR_W = 10;

  logic clk;
  logic resetn;
  int   checks;
  int   errors;

  data_sram_resp_if #(.ADDR_W(ADDR_W)) bus ();

  data_sram_resp #(.ADDR_W(ADDR_W)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference state.
  logic [31:0] mdl [0:1023];
  logic [31:0] rd_exp;
  logic [31:0] hr_exp;
  logic [15:0] err_exp;
  logic        busy;

  // Randomized stimulus variables.
  logic        en, we, hv, hwe, rr, oor, acc;
  logic [31:0] addr, wd, hwd;
  logic [9:0]  ha, idx;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cpu(input logic e, input logic w, input logic [31:0] a, input logic [31:0] d);
    bus.data_sram_en    = e;
    bus.data_sram_we    = w;
    bus.data_sram_addr  = a;
    bus.data_sram_wdata = d;
  endtask

  task automatic host(input logic v, input logic w, input logic [9:0] a, input logic [31:0] d);
    bus.host_req_valid = v;
    bus.host_we        = w;
    bus.host_addr      = a;
    bus.host_wdata     = d;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    cpu(1'b0, 1'b0, 32'd0, 32'd0);
    host(1'b0, 1'b0, 10'd0, 32'd0);
    bus.host_rsp_ready = 1'b0;
    resetn = 1'b0;
    #1;
    chk("reset_rdata", bus.data_sram_rdata, 32'd0);
    chk("reset_rsp_valid", {31'd0, bus.host_rsp_valid}, 32'd0);
    chk("reset_host_rdata", bus.host_rdata, 32'd0);
    chk("reset_err_cnt", {16'd0, bus.err_cnt}, 32'd0);
    step();
    step();
    resetn = 1'b1;
    step();

    // CPU write then read-back, rdata held through idle cycles.
    cpu(1'b1, 1'b1, 32'h10, 32'hDEADBEEF);
    step();
    chk("cpu_wr_no_rdata", bus.data_sram_rdata, 32'd0);
    cpu(1'b1, 1'b0, 32'h10, 32'd0);
    step();
    chk("cpu_rd_after_wr", bus.data_sram_rdata, 32'hDEADBEEF);
    cpu(1'b0, 1'b0, 32'h10, 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("cpu_rdata_hold", bus.data_sram_rdata, 32'hDEADBEEF);
    end

    // Host write while CPU idle, then CPU reads it back.
    host(1'b1, 1'b1, 10'd5, 32'h12345678);
    #1;
    chk("host_wr_ready", {31'd0, bus.host_req_ready}, 32'd1);
    step();
    chk("host_wr_rsp_valid", {31'd0, bus.host_rsp_valid}, 32'd1);
    chk("host_wr_rdata_zero", bus.host_rdata, 32'd0);
    host(1'b0, 1'b0, 10'd0, 32'd0);
    bus.host_rsp_ready = 1'b1;
    step();
    chk("host_wr_rsp_done", {31'd0, bus.host_rsp_valid}, 32'd0);
    bus.host_rsp_ready = 1'b0;
    cpu(1'b1, 1'b0, 32'h14, 32'd0);
    step();
    chk("cpu_rd_host_word", bus.data_sram_rdata, 32'h12345678);

    // Host read stalled by three CPU cycles, response held under backpressure.
    host(1'b1, 1'b0, 10'd5, 32'd0);
    for (int i = 0; i < 3; i++) begin
      cpu(1'b1, 1'b0, 32'h10, 32'd0);
      #1;
      chk("stall_ready_low", {31'd0, bus.host_req_ready}, 32'd0);
      step();
      chk("stall_no_rsp", {31'd0, bus.host_rsp_valid}, 32'd0);
    end
    cpu(1'b0, 1'b0, 32'd0, 32'd0);
    #1;
    chk("stall_ready_4th", {31'd0, bus.host_req_ready}, 32'd1);
    step();
    chk("host_rd_rsp_valid", {31'd0, bus.host_rsp_valid}, 32'd1);
    chk("host_rd_data", bus.host_rdata, 32'h12345678);
    host(1'b0, 1'b0, 10'd0, 32'd0);
    for (int i = 0; i < 2; i++) begin
      step();
      chk("rsp_hold_valid", {31'd0, bus.host_rsp_valid}, 32'd1);
      chk("rsp_hold_data", bus.host_rdata, 32'h12345678);
    end
    host(1'b1, 1'b1, 10'd7, 32'h0BADF00D);
    bus.host_rsp_ready = 1'b1;
    #1;
    chk("rsp_no_accept", {31'd0, bus.host_req_ready}, 32'd0);
    step();
    chk("rsp_drop", {31'd0, bus.host_rsp_valid}, 32'd0);
    host(1'b0, 1'b0, 10'd0, 32'd0);
    bus.host_rsp_ready = 1'b0;
    chk("cpu_rdata_untouched", bus.data_sram_rdata, 32'hDEADBEEF);

    // Out-of-range accesses.
    cpu(1'b1, 1'b0, 32'h0001_0010, 32'd0);
    step();
    chk("oor_read_zero", bus.data_sram_rdata, 32'd0);
    cpu(1'b1, 1'b1, 32'h0001_0010, 32'h00000BAD);
    step();
    cpu(1'b1, 1'b0, 32'h10, 32'd0);
    step();
    chk("oor_write_dropped", bus.data_sram_rdata, 32'hDEADBEEF);
    chk("oor_err_cnt_2", {16'd0, bus.err_cnt}, 32'd2);

    // Randomized phase over words 16..31.
    err_exp = 16'd2;
    rd_exp  = 32'hDEADBEEF;
    hr_exp  = 32'd0;
    busy    = 1'b0;
    hv      = 1'b0;
    hwe     = 1'b0;
    ha      = 10'd0;
    hwd     = 32'd0;
    for (int w = 16; w < 32; w++) begin
      wd = $urandom;
      mdl[w] = wd;
      cpu(1'b1, 1'b1, w << 2, wd);
      step();
    end
    for (int n = 0; n < 3000; n++) begin
      en  = ($urandom_range(0, 9) < 4);
      we  = 1'($urandom_range(0, 1));
      wd  = $urandom;
      oor = ($urandom_range(0, 9) == 0);
      idx = 10'(16 + $urandom_range(0, 15));
      if (oor) addr = ($urandom & 32'hFFFF_F000) | 32'h0010_0000 | ($urandom & 32'hFFF);
      else     addr = {20'd0, idx, 2'($urandom_range(0, 3))};
      if (!hv && ($urandom_range(0, 1) == 1)) begin
        hv  = 1'b1;
        hwe = 1'($urandom_range(0, 1));
        ha  = 10'(16 + $urandom_range(0, 15));
        hwd = $urandom;
      end
      rr = 1'($urandom_range(0, 1));
      cpu(en, we, addr, wd);
      host(hv, hwe, ha, hwd);
      bus.host_rsp_ready = rr;
      #1;
      chk("rnd_ready", {31'd0, bus.host_req_ready}, {31'd0, !busy && !en});
      acc = 1'b0;
      if (en) begin
        if (oor) begin
          if (err_exp != 16'hFFFF) err_exp = err_exp + 16'd1;
          if (!we) rd_exp = 32'd0;
        end else if (we) begin
          mdl[idx] = wd;
        end else begin
          rd_exp = mdl[idx];
        end
      end
      if (busy) begin
        if (rr) busy = 1'b0;
      end else if (hv && !en) begin
        acc = 1'b1;
        if (hwe) begin
          mdl[ha] = hwd;
          hr_exp  = 32'd0;
        end else begin
          hr_exp = mdl[ha];
        end
      end
      if (acc) begin
        busy = 1'b1;
        hv   = 1'b0;
      end
      step();
      chk("rnd_cpu_rdata", bus.data_sram_rdata, rd_exp);
      chk("rnd_rsp_valid", {31'd0, bus.host_rsp_valid}, {31'd0, busy});
      if (busy) chk("rnd_host_rdata", bus.host_rdata, hr_exp);
      chk("rnd_err_cnt", {16'd0, bus.err_cnt}, {16'd0, err_exp});
    end
    host(1'b0, 1'b0, 10'd0, 32'd0);
    bus.host_rsp_ready = 1'b1;
    cpu(1'b0, 1'b0, 32'd0, 32'd0);
    step();
    bus.host_rsp_ready = 1'b0;

    // Saturation of the error counter.
    cpu(1'b1, 1'b0, 32'h8000_0000, 32'd0);
    for (int i = 0; i < 70000; i++) step();
    chk("err_cnt_saturated", {16'd0, bus.err_cnt}, 32'h0000FFFF);

    // Asynchronous reset in the middle of a host response.
    cpu(1'b1, 1'b0, 32'h10, 32'd0);
    step();
    chk("pre_reset_rdata", bus.data_sram_rdata, 32'hDEADBEEF);
    cpu(1'b0, 1'b0, 32'd0, 32'd0);
    host(1'b1, 1'b0, 10'd5, 32'd0);
    step();
    host(1'b0, 1'b0, 10'd0, 32'd0);
    chk("pre_reset_rsp_valid", {31'd0, bus.host_rsp_valid}, 32'd1);
    chk("pre_reset_host_rdata", bus.host_rdata, 32'h12345678);
    #2;
    resetn = 1'b0;
    #1;
    chk("async_rst_rsp_valid", {31'd0, bus.host_rsp_valid}, 32'd0);
    chk("async_rst_rdata", bus.data_sram_rdata, 32'd0);
    chk("async_rst_host_rdata", bus.host_rdata, 32'd0);
    chk("async_rst_err_cnt", {16'd0, bus.err_cnt}, 32'd0);
    cpu(1'b1, 1'b1, 32'h14, 32'hFFFFFFFF);
    host(1'b1, 1'b1, 10'd5, 32'hFFFFFFFF);
    step();
    step();
    cpu(1'b0, 1'b0, 32'd0, 32'd0);
    host(1'b0, 1'b0, 10'd0, 32'd0);
    #3;
    resetn = 1'b1;
    step();
    chk("post_rst_rsp_valid", {31'd0, bus.host_rsp_valid}, 32'd0);
    cpu(1'b1, 1'b0, 32'h14, 32'd0);
    step();
    chk("post_rst_word5", bus.data_sram_rdata, 32'h12345678);
    cpu(1'b0, 1'b0, 32'd0, 32'd0);
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
